// File: rtl/fetch_rsp_buffer.sv
// -----------------------------------------------------------------------------
// fetch_rsp_buffer
//
// Instruction fetch response buffer that sits between the fetch bus interface
// and the decode stage. It tracks outstanding fetch requests, stores returned
// instruction words together with their fetch status, and grants a new request
// only when every in-flight response is guaranteed a slot. On a pipeline flush
// the buffer empties and the responses of all older in-flight requests are
// silently discarded as they arrive.
//
// Parameters:
//   DEPTH     number of buffer entries (power of two, 2..16)
//   MAX_PEND  maximum in-flight fetch requests (<= DEPTH)
//
// Ports:
//   s_clk_i        clock
//   s_resetn_i     asynchronous active-low reset
//   s_flush_i      pipeline redirect; empties buffer, discards older responses
//   s_req_i        fetch request accepted by the bus this cycle
//   s_grant_o      fetch may issue a request this cycle
//   s_rsp_i        fetch response valid this cycle
//   s_rsp_data_i   returned instruction word
//   s_rsp_err_i    returned fetch status (FETCH_VALID, FETCH_BSERR, ...)
//   s_dout_val_o   head entry valid
//   s_dout_data_o  head instruction word
//   s_dout_err_o   head fetch status
//   s_pop_i        decode consumes head (effective only when s_dout_val_o)
//   s_empty_o      buffer holds zero entries
//
// Configuration macro:
//   IFB_BYPASS_EN  when defined, a response arriving at an empty buffer with
//                  nothing to discard is presented on s_dout_* in the same
//                  cycle; if it is popped that cycle it is never stored.
// -----------------------------------------------------------------------------
module fetch_rsp_buffer #(
  parameter int DEPTH    = 4,
  parameter int MAX_PEND = 4
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic        s_req_i,
  output logic        s_grant_o,
  input  logic        s_rsp_i,
  input  logic [31:0] s_rsp_data_i,
  input  logic [2:0]  s_rsp_err_i,
  output logic        s_dout_val_o,
  output logic [31:0] s_dout_data_o,
  output logic [2:0]  s_dout_err_o,
  input  logic        s_pop_i,
  output logic        s_empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int GW = CW + 1;

  // Storage
  logic [31:0]   mem_data [DEPTH];
  logic [2:0]    mem_err  [DEPTH];

  // Control state
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pend;
  logic [PW-1:0] disc;

  // Per-cycle decisions
  logic          rsp_ok;    // response that matches an outstanding request
  logic          rsp_keep;  // response that belongs to the current stream
  logic          rd_en;     // head leaves storage
  logic          wr_en;     // response enters storage
  logic          byp_take;  // response consumed directly, never stored
  logic [GW-1:0] occ;       // slots already promised: stored + still owed
`ifdef IFB_BYPASS_EN
  logic          byp_hit;
`endif

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    rsp_ok   = s_rsp_i && (pend != '0);
    rsp_keep = rsp_ok && (disc == '0) && !s_flush_i;
    rd_en    = s_pop_i && (cnt != '0) && !s_flush_i;
`ifdef IFB_BYPASS_EN
    byp_hit  = rsp_keep && (cnt == '0);
    byp_take = byp_hit && s_pop_i;
`else
    byp_take = 1'b0;
`endif
    // A full buffer only accepts the word if the head leaves in the same cycle.
    wr_en    = rsp_keep && !byp_take && ((cnt != CW'(DEPTH)) || rd_en);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      pend   <= '0;
      disc   <= '0;
    end else begin
      // Requests and responses are counted even across a flush; a request in
      // the flush cycle already belongs to the new stream.
      pend <= pend + PW'(s_req_i) - PW'(rsp_ok);

      if (s_flush_i) begin
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        // Everything issued before this cycle, minus a response that arrives
        // now (dropped here), must still be thrown away.
        disc   <= pend - PW'(rsp_ok);
      end else begin
        if (rsp_ok && (disc != '0)) disc <= disc - 1'b1;
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en, rd_en})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // NOTE: the storage array is reset as well, so the head outputs and every
  // entry read back after reset are defined zeros rather than X.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_err[i]  <= '0;
      end
    end else if (wr_en) begin
      mem_data[wr_ptr] <= s_rsp_data_i;
      mem_err[wr_ptr]  <= s_rsp_err_i;
    end
  end

  // Grant uses registered state only; a pop in this cycle earns no credit.
  always_comb begin
    occ       = GW'(cnt) + GW'(pend) - GW'(disc);
    s_grant_o = (occ < GW'(DEPTH)) && (pend < PW'(MAX_PEND));
  end

  // Head outputs; stale storage contents are masked while nothing is held.
  always_comb begin
    s_empty_o     = (cnt == '0);
    s_dout_val_o  = (cnt != '0);
    s_dout_data_o = s_dout_val_o ? mem_data[rd_ptr] : '0;
    s_dout_err_o  = s_dout_val_o ? mem_err[rd_ptr]  : '0;
`ifdef IFB_BYPASS_EN
    if (byp_hit) begin
      s_dout_val_o  = 1'b1;
      s_dout_data_o = s_rsp_data_i;
      s_dout_err_o  = s_rsp_err_i;
    end
`endif
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is a bus protocol violation.
  a_rsp_without_req : assert property (
    @(posedge s_clk_i) disable iff (!s_resetn_i)
    !(s_rsp_i && (pend == '0)));

  // A kept response must find room unless the head leaves in the same cycle.
  a_write_when_full : assert property (
    @(posedge s_clk_i) disable iff (!s_resetn_i)
    !(rsp_keep && (cnt == CW'(DEPTH)) && !rd_en));
`endif

endmodule

// File: tb/tb_fetch_rsp_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_rsp_buffer
//
// Directed self-checking bench for fetch_rsp_buffer (DEPTH=4, MAX_PEND=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, well away from the next edge. Expected values are hand-derived
// constants. Builds with or without IFB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_fetch_rsp_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req;
  logic        grant;
  logic        rsp;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_err;
  logic        dout_val;
  logic [31:0] dout_data;
  logic [2:0]  dout_err;
  logic        pop;
  logic        empty;

  int n_checks;
  int n_fail;

  fetch_rsp_buffer #(.DEPTH(4), .MAX_PEND(4)) dut (
    .s_clk_i       (clk),
    .s_resetn_i    (rst_n),
    .s_flush_i     (flush),
    .s_req_i       (req),
    .s_grant_o     (grant),
    .s_rsp_i       (rsp),
    .s_rsp_data_i  (rsp_data),
    .s_rsp_err_i   (rsp_err),
    .s_dout_val_o  (dout_val),
    .s_dout_data_o (dout_data),
    .s_dout_err_o  (dout_err),
    .s_pop_i       (pop),
    .s_empty_o     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One clock: inputs set beforehand are sampled at the edge, then return to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    req      = 1'b0;
    rsp      = 1'b0;
    pop      = 1'b0;
    rsp_data = '0;
    rsp_err  = '0;
  endtask

  logic [31:0] words  [4];
  logic [31:0] words2 [4];

  initial begin
    words  = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    words2 = '{32'h0000_0297, 32'h0000_0317, 32'h0000_0397, 32'h0000_0417};
    n_checks = 0;
    n_fail   = 0;
    flush = 0; req = 0; rsp = 0; pop = 0; rsp_data = '0; rsp_err = '0;

    // ---- reset ----
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_val",   32'(dout_val),  32'd0);
    check("rst_data",  dout_data,      32'd0);
    check("rst_err",   32'(dout_err),  32'd0);
    check("rst_empty", 32'(empty),     32'd1);
    check("rst_grant", 32'(grant),     32'd1);
    rst_n = 1'b1;
    cyc();
    check("idle_grant", 32'(grant), 32'd1);

    // ---- fill and drain twice; the second pass wraps the pointers ----
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        check("grant_before_req", 32'(grant), 32'd1);
        req = 1'b1;
        cyc();
      end
      check("grant_pend_max", 32'(grant), 32'd0);
      for (int i = 0; i < 4; i++) begin
        rsp = 1'b1; rsp_data = words[i];
        cyc();
        if (i == 0) begin
          check("first_rsp_val",  32'(dout_val), 32'd1);
          check("first_rsp_data", dout_data,     words[0]);
        end
      end
      check("full_grant", 32'(grant), 32'd0);
      check("full_empty", 32'(empty), 32'd0);
      for (int i = 0; i < 4; i++) begin
        check("drain_val",  32'(dout_val), 32'd1);
        check("drain_data", dout_data,     words[i]);
        pop = 1'b1;
        cyc();
      end
      check("drained_empty", 32'(empty),    32'd1);
      check("drained_val",   32'(dout_val), 32'd0);
      check("drained_grant", 32'(grant),    32'd1);
    end

    // ---- write into a full buffer together with a pop ----
    for (int i = 0; i < 4; i++) begin
      req = 1'b1;
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      rsp = 1'b1; rsp_data = words2[i];
      cyc();
    end
    // One extra request beyond grant so a response can target the full buffer.
    req = 1'b1;
    cyc();
    check("full_head", dout_data, words2[0]);
    pop = 1'b1; rsp = 1'b1; rsp_data = 32'hDEAD_BEEF;
    cyc();
    check("full_pw_empty", 32'(empty), 32'd0);
    check("full_pw_grant", 32'(grant), 32'd0);
    for (int i = 1; i < 5; i++) begin
      check("full_pw_data", dout_data, (i < 4) ? words2[i] : 32'hDEAD_BEEF);
      pop = 1'b1;
      cyc();
    end
    check("full_pw_drained", 32'(empty), 32'd1);

    // ---- flush with a same-cycle response, request and pop ----
    req = 1'b1;
    cyc();
    rsp = 1'b1; rsp_data = 32'h0040_0213;
    cyc();
    check("pre_flush_val", 32'(dout_val), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("pre_flush_grant", 32'(grant), 32'd1);
      req = 1'b1;
      cyc();
    end
    flush = 1'b1; rsp = 1'b1; rsp_data = 32'hBAD0_0000; req = 1'b1; pop = 1'b1;
    cyc();
    check("flush_val",   32'(dout_val), 32'd0);
    check("flush_empty", 32'(empty),    32'd1);
    check("flush_grant", 32'(grant),    32'd1);
    rsp = 1'b1; rsp_data = 32'hBAD0_0001;
    cyc();
    check("disc1_val", 32'(dout_val), 32'd0);
    rsp = 1'b1; rsp_data = 32'hBAD0_0002;
    cyc();
    check("disc2_val", 32'(dout_val), 32'd0);
    rsp = 1'b1; rsp_data = 32'h1234_5678;
    cyc();
    check("new_stream_val",  32'(dout_val), 32'd1);
    check("new_stream_data", dout_data,     32'h1234_5678);
    check("new_stream_grant", 32'(grant),   32'd1);
    pop = 1'b1;
    cyc();
    check("new_stream_empty", 32'(empty), 32'd1);

    // ---- bus error status travels with its data ----
    req = 1'b1;
    cyc();
    rsp = 1'b1; rsp_data = 32'h0000_0073; rsp_err = 3'd1;
    cyc();
    check("bserr_err",  32'(dout_err), 32'd1);
    check("bserr_data", dout_data,     32'h0000_0073);
    pop = 1'b1;
    cyc();
    check("bserr_cleared_val", 32'(dout_val), 32'd0);
    check("bserr_cleared_err", 32'(dout_err), 32'd0);

    // ---- response plus pop into an empty buffer ----
    req = 1'b1;
    cyc();
    rsp = 1'b1; rsp_data = 32'hCAFE_BABE; pop = 1'b1;
    #1;
`ifdef IFB_BYPASS_EN
    check("byp_same_val",  32'(dout_val), 32'd1);
    check("byp_same_data", dout_data,     32'hCAFE_BABE);
    check("byp_same_empty", 32'(empty),   32'd1);
`else
    check("nobyp_same_val", 32'(dout_val), 32'd0);
`endif
    cyc();
`ifdef IFB_BYPASS_EN
    check("byp_after_val",   32'(dout_val), 32'd0);
    check("byp_after_empty", 32'(empty),    32'd1);
`else
    check("nobyp_after_val",  32'(dout_val), 32'd1);
    check("nobyp_after_data", dout_data,     32'hCAFE_BABE);
    pop = 1'b1;
    cyc();
    check("nobyp_drained", 32'(empty), 32'd1);
`endif
    check("end_grant", 32'(grant), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_rsp_buffer.md
# fetch_rsp_buffer

Instruction fetch response buffer between the fetch bus interface and the decode stage. It tracks outstanding fetch requests and stores returned instruction words with their fetch status (FETCH_* codes from p_hardisc). It grants new requests only when every in-flight response is guaranteed a slot. On a pipeline flush it silently discards the responses of requests issued before the flush.

## Interface
Parameters:
- DEPTH, 4, number of buffer entries (power of two, 2..16).
- MAX_PEND, 4, maximum in-flight fetch requests (≤ DEPTH).

Ports. One clock; reset is asynchronous and active-low.
- s_clk_i  in  1  clock
- s_resetn_i  in  1  asynchronous active-low reset
- s_flush_i  in  1  pipeline redirect; clears buffer and marks older in-flight requests for discard
- s_req_i  in  1  fetch request accepted by the bus this cycle
- s_grant_o  out  1  fetch may issue a request this cycle
- s_rsp_i  in  1  fetch response valid this cycle
- s_rsp_data_i  in  32  instruction word
- s_rsp_err_i  in  3  fetch status (FETCH_VALID, FETCH_BSERR, …)
- s_dout_val_o  out  1  head entry valid
- s_dout_data_o  out  32  head instruction word
- s_dout_err_o  out  3  head fetch status
- s_pop_i  in  1  decode consumes head (effective only when s_dout_val_o)
- s_empty_o  out  1  buffer holds zero entries

## Operation
State:
- cnt: occupied entries, 0..DEPTH.
- pend: expected responses, 0..MAX_PEND.
- disc: leading responses to drop, ≤ pend.
- Read/write pointers, modulo DEPTH; they wrap naturally.

Update rules:
- pend_next = pend + s_req_i − s_rsp_i. A response with pend==0 is a protocol violation; it is dropped and an assertion fires.
- Response with disc>0: dropped; disc decrements.
- Response with disc==0 and no flush: written at the write pointer. If cnt==DEPTH without a same-cycle pop, that is a violation; it is dropped and an assertion fires.
- Effective pop (s_pop_i & s_dout_val_o & !s_flush_i): read pointer advances, cnt decrements. A pop on empty is ignored.
- Simultaneous accepted write and pop: cnt unchanged, both pointers advance. This is legal when full.
- s_grant_o = (cnt + pend − disc < DEPTH) & (pend < MAX_PEND). It is combinational from registered state only; no same-cycle pop credit.

Flush behaviour (s_flush_i has priority over everything):
- cnt and both pointers go to 0.
- Any pop that cycle is ignored.
- A response arriving that cycle is dropped.
- disc_next = pend − s_rsp_i, so every request issued before the flush cycle is discarded.
- s_req_i in the flush cycle belongs to the new stream and is not discarded.
- A flush while disc>0 recomputes disc by the same formula.
- Outputs: s_empty_o = (cnt==0); s_dout_* driven from the head entry.

## Timing
- Reset values: s_dout_val_o=0, s_dout_data_o=0, s_dout_err_o=0, s_empty_o=1, s_grant_o=1.
- Reset clears cnt, pend, disc, pointers and all storage.
- Reset mid-operation abandons all state immediately; any bus responses afterwards are the integrator's responsibility.
- Latency, default build: response at cycle N → s_dout_val_o at N+1.
- Flush at N: s_dout_val_o=0 and s_empty_o=1 at N+1. The first new-stream response is visible one cycle after it arrives.
- s_grant_o reflects the state registered at the cycle start. A request at N is counted in the grant at N+1.

## Configuration
- IFB_BYPASS_EN defined: when cnt==0, disc==0, no flush, and a response arrives, s_dout_val_o/data/err show the response combinationally in the same cycle.
  - If s_pop_i is also high, the word is consumed and not written; cnt stays 0.
  - Otherwise it is written normally.
  - s_empty_o still reflects registered cnt.
- IFB_BYPASS_EN undefined: outputs come from storage only, with the one-cycle latency above.

## Test plan
- Reset, then idle: s_dout_val_o=0, s_empty_o=1, s_grant_o=1. Four requests with no responses: grant falls to 0 after the 4th request (pend=4).
- Four responses 0x00000013, 0x00100093, 0x00200113, 0x00300193 with no pops: cnt=4, grant=0. Pop on each of 4 cycles: words appear in order, then s_empty_o=1. Pointer wrap is covered by repeating this twice.
- Full buffer (cnt=4) with pop and response 0xDEADBEEF in the same cycle: cnt stays 4. 0xDEADBEEF emerges after the remaining three older words.
- pend=3, flush with a same-cycle response and a same-cycle new request: disc=2, pend=3. The next two responses are dropped. The third (0x12345678) appears on s_dout_data_o.
- Response with s_rsp_err_i=FETCH_BSERR (3'd1): s_dout_err_o=3'd1 with the accompanying data preserved.
- With IFB_BYPASS_EN, empty buffer, response 0xCAFEBABE plus s_pop_i in the same cycle: s_dout_val_o=1 that cycle and cnt remains 0. Without the macro: s_dout_val_o=1 one cycle later.
